// File: rtl/cavlc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : cavlc_pkg                                                       |
// | Brief    : Shared CAVLC types: nC class encoding, max coeff_token length,  |
// |            coeff_token encoder FSM state encoding, LUT index helper.       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package cavlc_pkg;

   // nC context class selecting the coeff_token VLC table
   typedef enum logic [2:0] {
      NC_0_2       = 3'd0,
      NC_2_4       = 3'd1,
      NC_4_8       = 3'd2,
      NC_8_UP      = 3'd3,
      NC_CHROMA_DC = 3'd4
   } nc_class_t;

   // Longest coeff_token codeword in any table
   localparam int MAX_CT_LEN = 16;

   // Encoder flush FSM
   typedef logic [1:0] ct_state_t;
   localparam ct_state_t c_st_run   = 2'd0;
   localparam ct_state_t c_st_drain = 2'd1;
   localparam ct_state_t c_st_emit  = 2'd2;
   localparam ct_state_t c_st_done  = 2'd3;

   // Row-major table index: TotalCoeff selects the row of four TrailingOnes entries
   function automatic logic [6:0] ct_idx(input logic [4:0] tc, input logic [1:0] t1);
      return {tc, t1};
   endfunction

endpackage : cavlc_pkg
`default_nettype wire

// File: rtl/coeff_token_enc_lut.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : coeff_token_enc_lut                                             |
// | Brief    : Combinational coeff_token codeword lookup (H.264 Table 9-5).    |
// |            Returns right-justified code, length and an illegal flag.       |
// |            COEFF_TOKEN_CHROMA_DC_EN: include the nC=-1 (chroma DC) table;  |
// |            otherwise NcClass=4 is reported illegal.                        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module coeff_token_enc_lut
   import cavlc_pkg::*;
(
   input  logic [4:0]  total_coeff,
   input  logic [1:0]  trailing_ones,
   input  logic [2:0]  nc_class,
   output logic [15:0] code,
   output logic [4:0]  len,
   output logic        illegal
);

   // Tables hold only the low bits of each codeword; leading zeros come from len
   localparam logic [4:0] c_len_nc0 [0:67] = '{
      1,0,0,0,
      6,2,0,0,      8,6,3,0,      9,8,7,5,      10,9,8,6,
      11,10,9,7,    13,11,10,8,   13,13,11,9,   13,13,13,10,
      14,14,13,11,  14,14,14,13,  15,15,14,14,  15,15,15,14,
      16,15,15,15,  16,16,16,15,  16,16,16,16,  16,16,16,16};
   localparam logic [3:0] c_bits_nc0 [0:67] = '{
      1,0,0,0,
      5,1,0,0,      7,4,1,0,      7,6,5,3,      7,6,5,3,
      7,6,5,4,      15,6,5,4,     11,14,5,4,    8,10,13,4,
      15,14,9,4,    11,10,13,12,  15,14,9,12,   11,10,13,8,
      15,1,9,12,    11,14,13,8,   7,10,9,12,    4,6,5,8};
   localparam logic [4:0] c_len_nc1 [0:67] = '{
      2,0,0,0,
      6,2,0,0,      6,5,3,0,      7,6,6,4,      8,6,6,4,
      8,7,7,5,      9,8,8,6,      11,9,9,6,     11,11,11,7,
      12,11,11,9,   12,12,12,11,  12,12,12,11,  13,13,13,12,
      13,13,13,13,  13,14,13,13,  14,14,14,13,  14,14,14,14};
   localparam logic [3:0] c_bits_nc1 [0:67] = '{
      3,0,0,0,
      11,2,0,0,     7,7,3,0,      7,10,9,5,     7,6,5,4,
      4,6,5,6,      7,6,5,8,      15,6,5,4,     11,14,13,4,
      15,10,9,4,    11,14,13,12,  8,10,9,8,     15,14,13,12,
      11,10,9,12,   7,11,6,8,     9,8,10,1,     7,6,5,4};
   localparam logic [4:0] c_len_nc2 [0:67] = '{
      4,0,0,0,
      6,4,0,0,      6,5,4,0,      6,5,5,4,      7,5,5,4,
      7,5,5,4,      7,6,6,4,      7,6,6,4,      8,7,7,5,
      8,8,7,6,      9,8,8,7,      9,9,8,8,      9,9,9,8,
      10,9,9,9,     10,10,10,10,  10,10,10,10,  10,10,10,10};
   localparam logic [3:0] c_bits_nc2 [0:67] = '{
      15,0,0,0,
      15,14,0,0,    11,15,13,0,   8,12,14,12,   15,10,11,11,
      11,8,9,10,    9,14,13,9,    8,10,9,8,     15,14,13,13,
      11,14,10,12,  15,10,13,12,  11,14,9,12,   8,10,13,8,
      13,7,9,12,    9,12,11,10,   5,8,7,6,      1,4,3,2};
`ifdef COEFF_TOKEN_CHROMA_DC_EN
   localparam logic [4:0] c_len_cdc [0:19] = '{
      2,0,0,0,  6,1,0,0,  6,6,3,0,  6,7,7,6,  6,8,8,7};
   localparam logic [2:0] c_bits_cdc [0:19] = '{
      1,0,0,0,  7,1,0,0,  4,6,1,0,  3,3,2,5,  2,3,2,0};
`endif

   logic [6:0] w_idx;
   logic       w_bad_sym;

   assign w_idx     = ct_idx(total_coeff, trailing_ones);
   assign w_bad_sym = (total_coeff > 5'd16) || ({3'b000, trailing_ones} > total_coeff);

   // Select the table for the nC class; anything out of range is flagged, not encoded
   always_comb begin
      code    = '0;
      len     = '0;
      illegal = 1'b0;
      if (w_bad_sym) begin
         illegal = 1'b1;
      end else begin
         case (nc_class)
            NC_0_2: begin
               code = {12'd0, c_bits_nc0[w_idx]};
               len  = c_len_nc0[w_idx];
            end
            NC_2_4: begin
               code = {12'd0, c_bits_nc1[w_idx]};
               len  = c_len_nc1[w_idx];
            end
            NC_4_8: begin
               code = {12'd0, c_bits_nc2[w_idx]};
               len  = c_len_nc2[w_idx];
            end
            NC_8_UP: begin
               // 6-bit fixed-length code; TotalCoeff=16 wraps to 4'hF as intended
               if (total_coeff == 5'd0) code = 16'b000011;
               else                     code = {10'd0, 4'(total_coeff - 5'd1), trailing_ones};
               len = 5'd6;
            end
`ifdef COEFF_TOKEN_CHROMA_DC_EN
            NC_CHROMA_DC: begin
               if (total_coeff > 5'd4) begin
                  illegal = 1'b1;
               end else begin
                  code = {13'd0, c_bits_cdc[w_idx[4:0]]};
                  len  = c_len_cdc[w_idx[4:0]];
               end
            end
`endif
            default: illegal = 1'b1;
         endcase
      end
   end

endmodule : coeff_token_enc_lut
`default_nettype wire

// File: rtl/coeff_token_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : coeff_token_encoder                                             |
// | Brief    : CAVLC coeff_token encoder with MSB-first WORD_W-bit packer.     |
// |            Lookup stage -> bit accumulator -> output word register, with   |
// |            a flush FSM that emits the trailing partial word.               |
// |            COEFF_TOKEN_CHROMA_DC_EN enables NcClass=4 (chroma DC) coding.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module coeff_token_encoder
   import cavlc_pkg::*;
#(
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        total_coeff,
   input  logic [1:0]        trailing_ones,
   input  logic [2:0]        nc_class,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_word,
   output logic [6:0]        out_bitcnt,
   output logic              flush_done,
   output logic              err
);

   localparam int c_cat_w = WORD_W + MAX_CT_LEN;

   logic [15:0]        w_lut_code;
   logic [4:0]         w_lut_len;
   logic               w_lut_illegal;

   logic               r_rdy_en;
   logic               r_stage_vld;
   logic [15:0]        r_stage_code;
   logic [4:0]         r_stage_len;
   logic [WORD_W-1:0]  r_acc;
   logic [6:0]         r_acc_cnt;
   logic               r_out_vld;
   logic [WORD_W-1:0]  r_out_word;
   logic [6:0]         r_out_bitcnt;
   logic               r_err;
   ct_state_t          r_state;

   logic               w_accept;
   logic               w_out_free;
   logic               w_consume;
   logic               w_emit;
   logic               w_full;
   logic [6:0]         w_sum;
   logic [15:0]        w_code_lj;
   logic [c_cat_w-1:0] w_cat;
   logic [c_cat_w-1:0] w_cat_rem;
   logic [WORD_W-1:0]  w_word_top;
   logic [WORD_W-1:0]  w_rem_top;

   coeff_token_enc_lut u_lut (
      .total_coeff   (total_coeff),
      .trailing_ones (trailing_ones),
      .nc_class      (nc_class),
      .code          (w_lut_code),
      .len           (w_lut_len),
      .illegal       (w_lut_illegal)
   );

   // Handshake: the stage advances only when the output register can take a word
   assign w_out_free = !r_out_vld || out_ready;
   assign w_consume  = r_stage_vld && w_out_free;
   assign in_ready   = r_rdy_en && (r_state == c_st_run) && (!r_stage_vld || w_consume);
   assign w_accept   = in_valid && in_ready;
   assign w_emit     = (r_state == c_st_emit) && (r_acc_cnt != 7'd0) && w_out_free;

   // Append staged code just below the AccCnt bits already held (accumulator is MSB-aligned)
   assign w_code_lj  = r_stage_code << (5'd16 - r_stage_len);
   assign w_cat      = ({w_code_lj, {WORD_W{1'b0}}} >> r_acc_cnt) | {r_acc, {MAX_CT_LEN{1'b0}}};
   assign w_cat_rem  = w_cat << WORD_W;
   assign w_word_top = w_cat[c_cat_w-1 -: WORD_W];
   assign w_rem_top  = w_cat_rem[c_cat_w-1 -: WORD_W];
   assign w_sum      = r_acc_cnt + {2'b00, r_stage_len};
   assign w_full     = (w_sum >= 7'(WORD_W));

   assign out_valid  = r_out_vld;
   assign out_word   = r_out_word;
   assign out_bitcnt = r_out_bitcnt;
   assign err        = r_err;
   assign flush_done = (r_state == c_st_done);

   // Hold In_Ready low while in reset and release it on the first clock after
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rdy_en <= 1'b0;
      else        r_rdy_en <= 1'b1;
   end

   // Lookup stage: capture legal symbols, drop illegal ones and latch the sticky error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stage_vld  <= 1'b0;
         r_stage_code <= '0;
         r_stage_len  <= '0;
         r_err        <= 1'b0;
      end else begin
         if (w_accept && !w_lut_illegal) begin
            r_stage_vld  <= 1'b1;
            r_stage_code <= w_lut_code;
            r_stage_len  <= w_lut_len;
         end else if (w_consume) begin
            r_stage_vld  <= 1'b0;
         end
         if (w_accept && w_lut_illegal) r_err <= 1'b1;
      end
   end

   // Accumulator: keeps fewer than WORD_W leftover bits; flush emission empties it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc     <= '0;
         r_acc_cnt <= '0;
      end else if (w_consume) begin
         if (w_full) begin
            r_acc     <= w_rem_top;
            r_acc_cnt <= w_sum - 7'(WORD_W);
         end else begin
            r_acc     <= w_word_top;
            r_acc_cnt <= w_sum;
         end
      end else if (w_emit) begin
         r_acc     <= '0;
         r_acc_cnt <= '0;
      end
   end

   // Output register: word stays stable until accepted; reloads in the accept cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_vld    <= 1'b0;
         r_out_word   <= '0;
         r_out_bitcnt <= '0;
      end else if (w_consume && w_full) begin
         r_out_vld    <= 1'b1;
         r_out_word   <= w_word_top;
         r_out_bitcnt <= 7'(WORD_W);
      end else if (w_emit) begin
         r_out_vld    <= 1'b1;
         r_out_word   <= r_acc;
         r_out_bitcnt <= r_acc_cnt;
      end else if (out_ready) begin
         r_out_vld    <= 1'b0;
      end
   end

   // Flush sequencing: drain the stage, emit any partial word, wait for it to leave, pulse done
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_st_run;
      end else begin
         case (r_state)
            c_st_run:   if (flush)        r_state <= c_st_drain;
            c_st_drain: if (!r_stage_vld) r_state <= c_st_emit;
            c_st_emit:  if ((r_acc_cnt == 7'd0) && w_out_free) r_state <= c_st_done;
            c_st_done:  r_state <= c_st_run;
            default:    r_state <= c_st_run;
         endcase
      end
   end

endmodule : coeff_token_encoder
`default_nettype wire

// File: tb/tb_coeff_token_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_coeff_token_encoder                                          |
// | Brief    : Directed bench for coeff_token_encoder. A bit-serial packer     |
// |            model queues expected words; a negedge monitor pops them.       |
// |            Honours COEFF_TOKEN_CHROMA_DC_EN for the NcClass=4 case.        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_coeff_token_encoder;

   typedef struct packed {
      logic [31:0] w;
      logic [6:0]  n;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  total_coeff;
   logic [1:0]  trailing_ones;
   logic [2:0]  nc_class;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_word;
   logic [6:0]  out_bitcnt;
   logic        flush_done;
   logic        err;

   int          n_vec = 0;
   int          n_bad = 0;
   exp_t        sb_q[$];
   logic [31:0] m_bits = '0;
   int          m_cnt = 0;

   coeff_token_encoder #(.WORD_W(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .total_coeff   (total_coeff),
      .trailing_ones (trailing_ones),
      .nc_class      (nc_class),
      .flush         (flush),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_word      (out_word),
      .out_bitcnt    (out_bitcnt),
      .flush_done    (flush_done),
      .err           (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Serial reference packer, MSB-first into 32-bit words
   task automatic model_put(input logic [15:0] code, input int len);
      for (int i = len - 1; i >= 0; i--) begin
         m_bits[31 - m_cnt] = code[i];
         m_cnt++;
         if (m_cnt == 32) begin
            sb_q.push_back({m_bits, 7'd32});
            m_bits = '0;
            m_cnt  = 0;
         end
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input int tc, input int t1, input int nc,
                       input logic [15:0] code, input int len, input bit legal);
      bit ok = 1'b0;
      total_coeff   = 5'(tc);
      trailing_ones = 2'(t1);
      nc_class      = 3'(nc);
      in_valid      = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = (in_ready === 1'b1);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      chk("in_ready_seen", 64'(ok), 64'd1);
      if (ok && legal) model_put(code, len);
   endtask

   task automatic do_flush();
      bit seen = 1'b0;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      if (m_cnt > 0) begin
         sb_q.push_back({m_bits, 7'(m_cnt)});
         m_bits = '0;
         m_cnt  = 0;
      end
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (flush_done === 1'b1) seen = 1'b1;
      end
      chk("flush_done", 64'(seen), 64'd1);
      chk("queue_drained_at_done", 64'(sb_q.size()), 64'd0);
      step(1);
   endtask

   // Scoreboard monitor: every accepted word must match the head of the expected queue
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         n_vec++;
         assert (sb_q.size() > 0) else begin
            n_bad++;
            $error("FAIL unexpected_word: observed %0h expected no word", out_word);
         end
         if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("out_word", 64'(out_word), 64'(e.w));
            chk("out_bitcnt", 64'(out_bitcnt), 64'(e.n));
         end
      end
   end

   initial begin
      bit   stall_ok;
      exp_t head;
      rst_n = 1'b0; in_valid = 1'b0; total_coeff = '0; trailing_ones = '0;
      nc_class = '0; flush = 1'b0; out_ready = 1'b1;

      // Reset state
      #12;
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_word", 64'(out_word), 64'd0);
      chk("rst_out_bitcnt", 64'(out_bitcnt), 64'd0);
      chk("rst_flush_done", 64'(flush_done), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      step(1);
      chk("in_ready_after_rst", 64'(in_ready), 64'd1);

      // NcClass 0: 1 | 01 | 001 -> 0xA4000000, 6 bits
      send(0, 0, 0, 16'h1, 1, 1'b1);
      send(1, 1, 0, 16'h1, 2, 1'b1);
      send(2, 2, 0, 16'h1, 3, 1'b1);
      do_flush();

      // NcClass 0: 0000101 | 0000100 -> 0x0A100000, 14 bits
      send(3, 2, 0, 16'h5, 7, 1'b1);
      send(5, 3, 0, 16'h4, 7, 1'b1);
      do_flush();

      // Exact fill: 32 one-bit codes -> one full word, then an empty flush
      for (int i = 0; i < 32; i++) send(0, 0, 0, 16'h1, 1, 1'b1);
      do_flush();

      // Backpressure: 5x 000011 + 11 fills a word; then stall with Out_Ready low
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(0, 0, 3, 16'h3, 6, 1'b1);
      send(0, 0, 1, 16'h3, 2, 1'b1);
      send(0, 0, 1, 16'h3, 2, 1'b1);
      head = sb_q[0];
      total_coeff = 5'd0; trailing_ones = 2'd0; nc_class = 3'd3; in_valid = 1'b1;
      stall_ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!(in_ready === 1'b0 && out_valid === 1'b1 && out_word === head.w)) stall_ok = 1'b0;
         @(posedge clk); #1;
      end
      chk("stall_hold", 64'(stall_ok), 64'd1);
      out_ready = 1'b1;
      send(0, 0, 3, 16'h3, 6, 1'b1);
      do_flush();

      // Chroma DC (0,0): coded 01 when enabled, illegal otherwise
      chk("err_before_illegal", 64'(err), 64'd0);
`ifdef COEFF_TOKEN_CHROMA_DC_EN
      send(0, 0, 4, 16'h1, 2, 1'b1);
      step(2);
      chk("err_chroma_dc", 64'(err), 64'd0);
`else
      send(0, 0, 4, 16'h0, 0, 1'b0);
      step(2);
      chk("err_chroma_dc", 64'(err), 64'd1);
`endif
      do_flush();

      // TrailingOnes > TotalCoeff: dropped, sticky error
      send(2, 3, 0, 16'h0, 0, 1'b0);
      step(2);
      chk("err_t1_gt_tc", 64'(err), 64'd1);
      do_flush();
      chk("err_sticky", 64'(err), 64'd1);

      // Reset with a full word pending and 9 leftover bits
      out_ready = 1'b0;
      for (int i = 0; i < 30; i++) send(0, 0, 0, 16'h1, 1, 1'b1);
      send(5, 0, 0, 16'h7, 11, 1'b1);
      step(3);
      head = sb_q[0];
      chk("pre_rst_valid", 64'(out_valid), 64'd1);
      chk("pre_rst_word", 64'(out_word), 64'(head.w));
      chk("pre_rst_word_const", 64'(out_word), 64'hFFFF_FFFC);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_out_word", 64'(out_word), 64'd0);
      chk("mid_rst_out_bitcnt", 64'(out_bitcnt), 64'd0);
      chk("mid_rst_flush_done", 64'(flush_done), 64'd0);
      chk("mid_rst_err", 64'(err), 64'd0);
      sb_q.delete();
      m_bits = '0;
      m_cnt  = 0;
      step(2);
      rst_n = 1'b1;
      step(1);
      chk("in_ready_after_rst2", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      do_flush();
      step(3);
      chk("final_queue_empty", 64'(sb_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule : tb_coeff_token_encoder
`default_nettype wire
